fwft_small_fifo: RTL and testbench

- Small synchronous first-word-fall-through (FWFT) FIFO, single clock.
- Used as the input buffer of AXI-Stream processing blocks such as the multihash encoder.
- Stores {tlast, tuser, tkeep, tdata} as one opaque word.
- The head word is always presented on dout while the FIFO is non-empty; rd_en acknowledges (pops) it.

---
 rtl/fwft_small_fifo.sv | 107 ++++++++++
 tb/tb_fwft_small_fifo.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fwft_small_fifo.sv
// Single-clock first-word-fall-through FIFO. The head word is held in a register, so
// dout is never a combinational path from din.
module fwft_small_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = (2 ** MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int unsigned DEPTH = 2 ** MAX_DEPTH_BITS;
  localparam int unsigned PW    = MAX_DEPTH_BITS;
  localparam int unsigned CW    = MAX_DEPTH_BITS + 1;

  localparam logic [CW-1:0] C_DEPTH    = CW'(DEPTH);
  localparam logic [CW-1:0] C_NEARLY   = CW'(DEPTH - 1);
  localparam logic [CW-1:0] C_PROG_THR = CW'(PROG_FULL_THRESHOLD);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;

  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [PW-1:0]    w_rd_ptr_inc;
  logic [PW-1:0]    w_wr_ptr_inc;
  logic [PW-1:0]    w_head_idx;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_count_after_pop;
  logic [WIDTH-1:0] w_dout_nxt;

  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == C_DEPTH);
  assign w_push       = wr_en & ~w_full;
  assign w_pop        = rd_en & ~w_empty;
  assign w_rd_ptr_inc = r_rd_ptr + PW'(1);
  assign w_wr_ptr_inc = r_wr_ptr + PW'(1);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_count_after_pop = r_count - CW'(w_pop);
  assign w_head_idx        = w_pop ? w_rd_ptr_inc : r_rd_ptr;

  // Next head word: when nothing older survives this edge the new head is the word
  // being written now, which is not yet in the array, so take it from din.
  always_comb begin
    w_dout_nxt = r_dout;
    if (w_count_nxt != '0) begin
      if (w_push && (w_count_after_pop == '0)) begin
        w_dout_nxt = din;
      end else begin
        w_dout_nxt = r_mem[w_head_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= w_wr_ptr_inc;
      end
      if (w_pop) begin
        r_rd_ptr <= w_rd_ptr_inc;
      end
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
    end
  end

  assign dout        = r_dout;
  assign empty       = w_empty;
  assign full        = w_full;
  assign nearly_full = (r_count >= C_NEARLY);
  assign prog_full   = (r_count >= C_PROG_THR);

endmodule

// File: tb/tb_fwft_small_fifo.sv
// Scoreboard bench for fwft_small_fifo: a queue holds the expected contents, and each
// accepted pop is compared against the queue head.
module tb_fwft_small_fifo;

  localparam int W = 72;
  localparam int D = 8;

  logic         clk;
  logic         resetn;
  logic [W-1:0] din;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] dout;
  logic         full;
  logic         nearly_full;
  logic         prog_full;
  logic         empty;

  logic [W-1:0] q[$];
  int           n_tests;
  int           n_fail;

  fwft_small_fifo #(
    .WIDTH              (W),
    .MAX_DEPTH_BITS     (3),
    .PROG_FULL_THRESHOLD(7)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .din        (din),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .dout       (dout),
    .full       (full),
    .nearly_full(nearly_full),
    .prog_full  (prog_full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] exp_flags(input int n);
    return {n == 0, n == D, n >= D - 1, n >= 7};
  endfunction

  // Called at posedge+1; drives one cycle and checks the state after the edge.
  task automatic step(input logic wr, input logic rd, input logic [W-1:0] d);
    logic acc_pop;
    logic acc_push;
    wr_en    = wr;
    rd_en    = rd;
    din      = d;
    acc_pop  = rd && (q.size() > 0);
    acc_push = wr && (q.size() < D);
    if (acc_pop) check("pop_data", dout, q[0]);
    @(posedge clk);
    #1;
    if (acc_pop) void'(q.pop_front());
    if (acc_push) q.push_back(d);
    check("flags", {60'd0, empty, full, nearly_full, prog_full}, {60'd0, exp_flags(q.size())});
    if (q.size() > 0) check("head", dout, q[0]);
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn  = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    din     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("rst_flags", {60'd0, empty, full, nearly_full, prog_full}, {60'd0, 4'b1000});
    check("rst_dout", dout, '0);

    // single word
    step(1'b1, 1'b0, 72'h0A5);
    check("single_dout", dout, 72'h0A5);
    check("single_empty", {71'd0, empty}, '0);
    step(1'b0, 1'b1, '0);
    check("single_drain", {71'd0, empty}, 72'd1);

    // fill to full, overflow dropped, ordered drain
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b0, 72'h99);
    check("ovf_full", {71'd0, full}, 72'd1);
    for (int i = 1; i <= D; i++) begin
      check("fill_order", dout, W'(i));
      step(1'b0, 1'b1, '0);
    end
    check("fill_empty", {71'd0, empty}, 72'd1);

    // full with simultaneous read and write: pop happens, write dropped
    for (int i = 1; i <= D; i++) step(1'b1, 1'b0, W'(i));
    step(1'b1, 1'b1, 72'h55);
    check("full_rw_occ", {60'd0, empty, full, nearly_full, prog_full}, {60'd0, 4'b0011});
    for (int i = 2; i <= D; i++) begin
      check("full_rw_order", dout, W'(i));
      step(1'b0, 1'b1, '0);
    end
    check("full_rw_empty", {71'd0, empty}, 72'd1);

    // streaming at occupancy 2
    step(1'b1, 1'b0, 72'h100);
    step(1'b1, 1'b0, 72'h101);
    for (int i = 0; i < 20; i++) begin
      check("stream_order", dout, W'(256 + i));
      step(1'b1, 1'b1, W'(258 + i));
      check("stream_occ", W'(q.size()), W'(2));
    end
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);

    // empty with simultaneous read and write; reads while empty ignored
    step(1'b1, 1'b1, 72'h3C);
    check("empty_rw_dout", dout, 72'h3C);
    check("empty_rw_flags", {60'd0, empty, full, nearly_full, prog_full}, {60'd0, 4'b0000});
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    step(1'b0, 1'b1, '0);
    check("empty_hold", dout, 72'h3C);

    // random traffic with wide data
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {8'($urandom), $urandom, $urandom});
    end
    while (q.size() > 0) step(1'b0, 1'b1, '0);

    // asynchronous reset with 5 words stored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, W'(72'hA00 + i));
    #2;
    resetn = 1'b0;
    #1;
    check("async_rst_flags", {60'd0, empty, full, nearly_full, prog_full}, {60'd0, 4'b1000});
    check("async_rst_dout", dout, '0);
    q.delete();
    @(posedge clk);
    #2;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_flags", {60'd0, empty, full, nearly_full, prog_full}, {60'd0, 4'b1000});
    step(1'b1, 1'b0, 72'hBEEF);
    check("post_rst_write", dout, 72'hBEEF);
    step(1'b0, 1'b1, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
